hetero_dir_multi: RTL and testbench

- Multi-entry CPU/GPU coherence directory with I/S/M per line; sharers tracked as separate CPU and GPU bitmasks.
- Successor to the single-line directory: direct-mapped table of N_ENTRIES lines, requester-aware updates, conflict-victim recall, explicit invalidation-ack collection before grant.
- Sits between the external client request arbiter and the CPU/GPU cache invalidation fabric.

---
 rtl/hetero_dir_multi.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_hetero_dir_multi.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hetero_dir_multi.sv
// hetero_dir_multi: direct-mapped CPU/GPU coherence directory (I/S/M per line).
// Each entry holds valid, tag, state and separate CPU/GPU sharer bitmasks.
// One request is in flight at a time. Each request goes through
// IDLE -> LOOKUP -> [INVAL -> WAIT] -> RESP.
// The directory recalls a conflicting victim line or invalidates the other
// sharers, and it collects every invalidation ack before it grants.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/ready         request handshake; ready only while idle
//   req_addr/type/src       line address, 0=Read 1=Write 2/3=Evict, client id
//   ack_valid/ack_src       invalidation ack from a client
//   inval_valid             one-cycle pulse qualifying cpu_inval/gpu_inval
//   resp_valid/src/grant    one-cycle completion: 1=S, 2=M, 3=evict done
module hetero_dir_multi #(
  parameter int N_CPU       = 4,
  parameter int N_GPU       = 8,
  parameter int LINE_ADDR_W = 32,
  parameter int N_ENTRIES   = 16,
  localparam int IDX_W      = $clog2(N_ENTRIES),
  localparam int SRC_W      = $clog2(N_CPU + N_GPU)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LINE_ADDR_W-1:0] req_addr,
  input  logic [1:0]             req_type,
  input  logic [SRC_W-1:0]       req_src,
  input  logic                   ack_valid,
  input  logic [SRC_W-1:0]       ack_src,
  output logic                   inval_valid,
  output logic [N_CPU-1:0]       cpu_inval,
  output logic [N_GPU-1:0]       gpu_inval,
  output logic                   resp_valid,
  output logic [SRC_W-1:0]       resp_src,
  output logic [1:0]             resp_grant
);

  localparam int          TAG_W  = LINE_ADDR_W - IDX_W;
  localparam int unsigned NCPU_U = N_CPU;
  localparam int unsigned NGPU_U = N_GPU;
  localparam int unsigned NENT_U = N_ENTRIES;

  localparam logic [1:0] GR_S  = 2'd1;
  localparam logic [1:0] GR_M  = 2'd2;
  localparam logic [1:0] GR_EV = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_INVAL, ST_WAIT, ST_RESP} fsm_e;
  typedef enum logic [1:0] {LS_I, LS_S, LS_M} line_e;

  // Client id to sharer bit; out-of-range ids map to no bit at all.
  function automatic logic [N_CPU-1:0] cpu_bit(input logic [SRC_W-1:0] id);
    logic [N_CPU-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < NCPU_U; i++)
      if (32'(id) == i) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [N_GPU-1:0] gpu_bit(input logic [SRC_W-1:0] id);
    logic [N_GPU-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < NGPU_U; i++)
      if (32'(id) == i + NCPU_U) b[i] = 1'b1;
    return b;
  endfunction

  // Directory table
  logic              ent_valid_q [N_ENTRIES];
  logic              ent_valid_d [N_ENTRIES];
  logic [TAG_W-1:0]  ent_tag_q   [N_ENTRIES];
  logic [TAG_W-1:0]  ent_tag_d   [N_ENTRIES];
  line_e             ent_state_q [N_ENTRIES];
  line_e             ent_state_d [N_ENTRIES];
  logic [N_CPU-1:0]  ent_cpu_q   [N_ENTRIES];
  logic [N_CPU-1:0]  ent_cpu_d   [N_ENTRIES];
  logic [N_GPU-1:0]  ent_gpu_q   [N_ENTRIES];
  logic [N_GPU-1:0]  ent_gpu_d   [N_ENTRIES];

  // Request context and staged entry update
  fsm_e                   state_q, state_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]             type_q, type_d;
  logic [SRC_W-1:0]       src_q, src_d;
  logic                   new_valid_q, new_valid_d;
  logic [TAG_W-1:0]       new_tag_q, new_tag_d;
  line_e                  new_state_q, new_state_d;
  logic [N_CPU-1:0]       new_cpu_q, new_cpu_d;
  logic [N_GPU-1:0]       new_gpu_q, new_gpu_d;
  logic [1:0]             grant_q, grant_d;
  logic [N_CPU-1:0]       pend_cpu_q, pend_cpu_d;
  logic [N_GPU-1:0]       pend_gpu_q, pend_gpu_d;

  // Registered outputs
  logic                   req_ready_q, req_ready_d;
  logic                   inval_valid_q, inval_valid_d;
  logic [N_CPU-1:0]       cpu_inval_q, cpu_inval_d;
  logic [N_GPU-1:0]       gpu_inval_q, gpu_inval_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [SRC_W-1:0]       resp_src_q, resp_src_d;
  logic [1:0]             resp_grant_q, resp_grant_d;

  assign req_ready   = req_ready_q;
  assign inval_valid = inval_valid_q;
  assign cpu_inval   = cpu_inval_q;
  assign gpu_inval   = gpu_inval_q;
  assign resp_valid  = resp_valid_q;
  assign resp_src    = resp_src_q;
  assign resp_grant  = resp_grant_q;

  // Lookup of the latched request against its indexed entry
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             e_valid;
  logic [TAG_W-1:0] e_tag;
  line_e            e_state;
  logic [N_CPU-1:0] e_cpu, s_cpu, b_cpu, lk_cpu, lk_mcpu, a_cpu;
  logic [N_GPU-1:0] e_gpu, s_gpu, b_gpu, lk_gpu, lk_mgpu, a_gpu;
  logic             hit, is_evict, victim;
  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;
  line_e            lk_state;
  logic [1:0]       lk_grant;

  assign idx      = addr_q[IDX_W-1:0];
  assign tag      = addr_q[LINE_ADDR_W-1:IDX_W];
  assign e_valid  = ent_valid_q[idx];
  assign e_tag    = ent_tag_q[idx];
  assign e_state  = ent_state_q[idx];
  assign e_cpu    = ent_cpu_q[idx];
  assign e_gpu    = ent_gpu_q[idx];
  assign s_cpu    = cpu_bit(src_q);
  assign s_gpu    = gpu_bit(src_q);
  assign a_cpu    = ack_valid ? cpu_bit(ack_src) : '0;
  assign a_gpu    = ack_valid ? gpu_bit(ack_src) : '0;
  assign hit      = e_valid && (e_tag == tag);
  assign is_evict = type_q[1];
  // An evict never recalls; it only acts on a line it hits.
  assign victim   = !hit && e_valid && (|{e_cpu, e_gpu}) && !is_evict;

  always_comb begin
    lk_valid = e_valid;
    lk_tag   = e_tag;
    lk_state = e_state;
    lk_cpu   = e_cpu;
    lk_gpu   = e_gpu;
    lk_mcpu  = '0;
    lk_mgpu  = '0;
    lk_grant = GR_EV;
    b_cpu    = hit ? e_cpu : '0;
    b_gpu    = hit ? e_gpu : '0;
    if (is_evict) begin
      if (hit) begin
        lk_cpu = e_cpu & ~s_cpu;
        lk_gpu = e_gpu & ~s_gpu;
        if ((lk_cpu == '0) && (lk_gpu == '0)) lk_state = LS_I;
      end
    end else begin
      lk_valid = 1'b1;
      lk_tag   = tag;
      // A victim recall empties the line first, so the request is then
      // applied to an empty entry and needs no further invalidations.
      if (victim) begin
        lk_mcpu = e_cpu;
        lk_mgpu = e_gpu;
      end
      if (type_q == 2'd1) begin
        lk_state = LS_M;
        lk_cpu   = s_cpu;
        lk_gpu   = s_gpu;
        lk_grant = GR_M;
        if (hit) begin
          lk_mcpu = e_cpu & ~s_cpu;
          lk_mgpu = e_gpu & ~s_gpu;
        end
      end else if (hit && (e_state == LS_M)) begin
        if ((e_cpu == s_cpu) && (e_gpu == s_gpu)) begin
          lk_grant = GR_M;
        end else begin
          lk_mcpu  = e_cpu;
          lk_mgpu  = e_gpu;
          lk_state = LS_S;
          lk_cpu   = s_cpu;
          lk_gpu   = s_gpu;
          lk_grant = GR_S;
        end
      end else begin
        lk_state = LS_S;
        lk_cpu   = b_cpu | s_cpu;
        lk_gpu   = b_gpu | s_gpu;
        lk_grant = GR_S;
      end
    end
  end

  logic             commit;
  logic             c_valid;
  logic [TAG_W-1:0] c_tag;
  line_e            c_state;
  logic [N_CPU-1:0] c_cpu;
  logic [N_GPU-1:0] c_gpu;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    type_d        = type_q;
    src_d         = src_q;
    new_valid_d   = new_valid_q;
    new_tag_d     = new_tag_q;
    new_state_d   = new_state_q;
    new_cpu_d     = new_cpu_q;
    new_gpu_d     = new_gpu_q;
    grant_d       = grant_q;
    pend_cpu_d    = pend_cpu_q;
    pend_gpu_d    = pend_gpu_q;
    inval_valid_d = 1'b0;
    cpu_inval_d   = '0;
    gpu_inval_d   = '0;
    resp_valid_d  = 1'b0;
    resp_src_d    = '0;
    resp_grant_d  = '0;
    ent_valid_d   = ent_valid_q;
    ent_tag_d     = ent_tag_q;
    ent_state_d   = ent_state_q;
    ent_cpu_d     = ent_cpu_q;
    ent_gpu_d     = ent_gpu_q;
    commit        = 1'b0;
    c_valid       = new_valid_q;
    c_tag         = new_tag_q;
    c_state       = new_state_q;
    c_cpu         = new_cpu_q;
    c_gpu         = new_gpu_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          type_d  = req_type;
          src_d   = req_src;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        new_valid_d = lk_valid;
        new_tag_d   = lk_tag;
        new_state_d = lk_state;
        new_cpu_d   = lk_cpu;
        new_gpu_d   = lk_gpu;
        grant_d     = lk_grant;
        if ((lk_mcpu == '0) && (lk_mgpu == '0)) begin
          state_d      = ST_RESP;
          commit       = 1'b1;
          c_valid      = lk_valid;
          c_tag        = lk_tag;
          c_state      = lk_state;
          c_cpu        = lk_cpu;
          c_gpu        = lk_gpu;
          resp_valid_d = 1'b1;
          resp_src_d   = src_q;
          resp_grant_d = lk_grant;
        end else begin
          state_d       = ST_INVAL;
          inval_valid_d = 1'b1;
          cpu_inval_d   = lk_mcpu;
          gpu_inval_d   = lk_mgpu;
        end
      end
      ST_INVAL: begin
        // The driven mask becomes the pending set; an ack in this cycle counts.
        pend_cpu_d = cpu_inval_q & ~a_cpu;
        pend_gpu_d = gpu_inval_q & ~a_gpu;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        pend_cpu_d = pend_cpu_q & ~a_cpu;
        pend_gpu_d = pend_gpu_q & ~a_gpu;
        if ((pend_cpu_d == '0) && (pend_gpu_d == '0)) begin
          state_d      = ST_RESP;
          commit       = 1'b1;
          resp_valid_d = 1'b1;
          resp_src_d   = src_q;
          resp_grant_d = grant_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (commit) begin
      ent_valid_d[idx] = c_valid;
      ent_tag_d[idx]   = c_tag;
      ent_state_d[idx] = c_state;
      ent_cpu_d[idx]   = c_cpu;
      ent_gpu_d[idx]   = c_gpu;
    end

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      type_q        <= '0;
      src_q         <= '0;
      new_valid_q   <= 1'b0;
      new_tag_q     <= '0;
      new_state_q   <= LS_I;
      new_cpu_q     <= '0;
      new_gpu_q     <= '0;
      grant_q       <= '0;
      pend_cpu_q    <= '0;
      pend_gpu_q    <= '0;
      req_ready_q   <= 1'b1;
      inval_valid_q <= 1'b0;
      cpu_inval_q   <= '0;
      gpu_inval_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_src_q    <= '0;
      resp_grant_q  <= '0;
      for (int unsigned i = 0; i < NENT_U; i++) begin
        ent_valid_q[i] <= 1'b0;
        ent_tag_q[i]   <= '0;
        ent_state_q[i] <= LS_I;
        ent_cpu_q[i]   <= '0;
        ent_gpu_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      type_q        <= type_d;
      src_q         <= src_d;
      new_valid_q   <= new_valid_d;
      new_tag_q     <= new_tag_d;
      new_state_q   <= new_state_d;
      new_cpu_q     <= new_cpu_d;
      new_gpu_q     <= new_gpu_d;
      grant_q       <= grant_d;
      pend_cpu_q    <= pend_cpu_d;
      pend_gpu_q    <= pend_gpu_d;
      req_ready_q   <= req_ready_d;
      inval_valid_q <= inval_valid_d;
      cpu_inval_q   <= cpu_inval_d;
      gpu_inval_q   <= gpu_inval_d;
      resp_valid_q  <= resp_valid_d;
      resp_src_q    <= resp_src_d;
      resp_grant_q  <= resp_grant_d;
      ent_valid_q   <= ent_valid_d;
      ent_tag_q     <= ent_tag_d;
      ent_state_q   <= ent_state_d;
      ent_cpu_q     <= ent_cpu_d;
      ent_gpu_q     <= ent_gpu_d;
    end
  end

endmodule

// File: tb/tb_hetero_dir_multi.sv
// Directed bench for hetero_dir_multi (4 CPU, 8 GPU, 16 entries).
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
module tb_hetero_dir_multi;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_type;
  logic [3:0]  req_src;
  logic        ack_valid;
  logic [3:0]  ack_src;
  logic        inval_valid;
  logic [3:0]  cpu_inval;
  logic [7:0]  gpu_inval;
  logic        resp_valid;
  logic [3:0]  resp_src;
  logic [1:0]  resp_grant;

  hetero_dir_multi #(
    .N_CPU(4),
    .N_GPU(8),
    .LINE_ADDR_W(32),
    .N_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_type(req_type),
    .req_src(req_src),
    .ack_valid(ack_valid),
    .ack_src(ack_src),
    .inval_valid(inval_valid),
    .cpu_inval(cpu_inval),
    .gpu_inval(gpu_inval),
    .resp_valid(resp_valid),
    .resp_src(resp_src),
    .resp_grant(resp_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Snapshot of every output: {ready, inval_valid, cpu, gpu, resp_valid, src, grant}
  typedef struct packed {
    logic       rr;
    logic       iv;
    logic [3:0] ci;
    logic [7:0] gi;
    logic       rv;
    logic [3:0] rs;
    logic [1:0] rg;
  } obs_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_o;

  function automatic obs_t obs();
    return '{req_ready, inval_valid, cpu_inval, gpu_inval, resp_valid, resp_src, resp_grant};
  endfunction
  function automatic obs_t o_idle();
    return '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 2'd0};
  endfunction
  function automatic obs_t o_busy();
    return '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 2'd0};
  endfunction
  function automatic obs_t o_inval(input logic [3:0] ci, input logic [7:0] gi);
    return '{1'b0, 1'b1, ci, gi, 1'b0, 4'h0, 2'd0};
  endfunction
  function automatic obs_t o_resp(input logic [3:0] s, input logic [1:0] g);
    return '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, s, g};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Called on a falling edge while idle; returns on the falling edge of the LOOKUP cycle.
  task automatic do_req(input logic [31:0] a, input logic [1:0] t, input logic [3:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_type  = t;
    req_src   = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_ack(input logic [3:0] s);
    ack_valid = 1'b1;
    ack_src   = s;
    @(negedge clk);
    ack_valid = 1'b0;
  endtask

  task automatic do_simple(input logic [31:0] a, input logic [1:0] t, input logic [3:0] s);
    do_req(a, t, s);
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs(), exp_o); end
    rst_n = 1'b1;
    tick();
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_read_miss();
    do_req(32'h100, 2'd0, 4'd1);
    exp_o = o_busy(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rd_lookup: got %h want %h", obs(), exp_o); end
    tick();
    exp_o = o_resp(4'd1, 2'd1); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rd_resp: got %h want %h", obs(), exp_o); end
    tick();
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rd_done: got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_write_upgrade();
    do_simple(32'h100, 2'd0, 4'd5);
    do_req(32'h100, 2'd1, 4'd1);
    tick();
    exp_o = o_inval(4'b0000, 8'b0000_0010); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL wr_inval: got %h want %h", obs(), exp_o); end
    tick();
    exp_o = o_busy(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL wr_wait: got %h want %h", obs(), exp_o); end
    do_ack(4'd5);
    exp_o = o_resp(4'd1, 2'd2); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL wr_resp: got %h want %h", obs(), exp_o); end
    tick();
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL wr_done: got %h want %h", obs(), exp_o); end
  endtask

  task automatic test_read_owned();
    // Line is M with owner 1.
    do_req(32'h100, 2'd0, 4'd6);
    tick();
    exp_o = o_inval(4'b0010, 8'h00); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rdm_inval: got %h want %h", obs(), exp_o); end
    tick();
    do_ack(4'd3);
    exp_o = o_busy(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rdm_stray: got %h want %h", obs(), exp_o); end
    do_ack(4'd3);
    exp_o = o_busy(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rdm_dup: got %h want %h", obs(), exp_o); end
    do_ack(4'd6);
    exp_o = o_busy(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rdm_self_ack: got %h want %h", obs(), exp_o); end
    do_ack(4'd1);
    exp_o = o_resp(4'd6, 2'd1); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rdm_resp: got %h want %h", obs(), exp_o); end
    tick();
    // Sharers must now be exactly {6}; the ack lands in the INVAL cycle.
    do_req(32'h100, 2'd1, 4'd2);
    tick();
    exp_o = o_inval(4'b0000, 8'b0000_0100); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rdm_sharers: got %h want %h", obs(), exp_o); end
    do_ack(4'd6);
    exp_o = o_busy(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL inval_ack_wait: got %h want %h", obs(), exp_o); end
    tick();
    exp_o = o_resp(4'd2, 2'd2); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL inval_ack_resp: got %h want %h", obs(), exp_o); end
    tick();
  endtask

  task automatic test_victim();
    // Line is M with owner 2; evicting the owner leaves it in I.
    do_req(32'h100, 2'd2, 4'd2);
    tick();
    exp_o = o_resp(4'd2, 2'd3); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_owner: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h100, 2'd0, 4'd0);
    tick();
    exp_o = o_resp(4'd0, 2'd1); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rd_after_ev: got %h want %h", obs(), exp_o); end
    tick();
    do_simple(32'h100, 2'd0, 4'd4);
    do_req(32'h110, 2'd0, 4'd2);
    tick();
    exp_o = o_inval(4'b0001, 8'b0000_0001); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL vic_inval: got %h want %h", obs(), exp_o); end
    tick();
    do_ack(4'd0);
    exp_o = o_busy(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL vic_partial: got %h want %h", obs(), exp_o); end
    do_ack(4'd4);
    exp_o = o_resp(4'd2, 2'd1); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL vic_resp: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h110, 2'd0, 4'd3);
    tick();
    exp_o = o_resp(4'd3, 2'd1); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL vic_tag_hit: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h110, 2'd1, 4'd3);
    tick();
    exp_o = o_inval(4'b0100, 8'h00); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL vic_sharers: got %h want %h", obs(), exp_o); end
    tick();
    do_ack(4'd2);
    exp_o = o_resp(4'd3, 2'd2); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL vic_wr_resp: got %h want %h", obs(), exp_o); end
    tick();
  endtask

  task automatic test_evict();
    do_req(32'h123, 2'd2, 4'd9);
    tick();
    exp_o = o_resp(4'd9, 2'd3); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_miss: got %h want %h", obs(), exp_o); end
    tick();
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_miss_done: got %h want %h", obs(), exp_o); end
    // 0x110 is M with owner 3; src 9 is not a sharer.
    do_req(32'h110, 2'd2, 4'd9);
    tick();
    exp_o = o_resp(4'd9, 2'd3); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_nonsharer: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h110, 2'd0, 4'd9);
    tick();
    exp_o = o_inval(4'b1000, 8'h00); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_owner_kept: got %h want %h", obs(), exp_o); end
    tick();
    do_ack(4'd3);
    exp_o = o_resp(4'd9, 2'd1); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_rd_resp: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h110, 2'd2, 4'd9);
    tick();
    exp_o = o_resp(4'd9, 2'd3); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_last: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h110, 2'd1, 4'd0);
    tick();
    exp_o = o_resp(4'd0, 2'd2); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL wr_nomask: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h110, 2'd3, 4'd0);
    tick();
    exp_o = o_resp(4'd0, 2'd3); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_type3: got %h want %h", obs(), exp_o); end
    tick();
    do_req(32'h110, 2'd1, 4'd5);
    tick();
    exp_o = o_resp(4'd5, 2'd2); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL ev_type3_cleared: got %h want %h", obs(), exp_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_simple(32'h124, 2'd0, 4'd7);
    do_req(32'h124, 2'd1, 4'd1);
    tick();
    exp_o = o_inval(4'b0000, 8'b0000_1000); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rst_inval: got %h want %h", obs(), exp_o); end
    tick();
    rst_n = 1'b0;
    #1;
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rst_async: got %h want %h", obs(), exp_o); end
    #1;
    rst_n = 1'b1;
    tick();
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rst_after: got %h want %h", obs(), exp_o); end
    do_req(32'h124, 2'd0, 4'd2);
    tick();
    exp_o = o_resp(4'd2, 2'd1); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rst_read: got %h want %h", obs(), exp_o); end
    tick();
    // Sharer 7 must be gone, so a write by the sole sharer needs no invalidation.
    do_req(32'h124, 2'd1, 4'd2);
    tick();
    exp_o = o_resp(4'd2, 2'd2); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rst_cleared: got %h want %h", obs(), exp_o); end
    tick();
    exp_o = o_idle(); n_checks++;
    if (obs() !== exp_o) begin n_fail++; $display("FAIL rst_final: got %h want %h", obs(), exp_o); end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_type  = '0;
    req_src   = '0;
    ack_valid = 1'b0;
    ack_src   = '0;
    test_reset();
    test_read_miss();
    test_write_upgrade();
    test_read_owned();
    test_victim();
    test_evict();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
